// File: rtl/multichannel_decoder_pkg.sv
// Shared constants for the spike-rate codec: sizes, codebook IDs
// and the decoder FSM state encoding.
package multichannel_decoder_pkg;

  localparam int CH_NUM              = 16;
  localparam int CH_BIT              = 4;
  localparam int SPIKE_RATE_BIT      = 4;
  localparam int ENCODER_NUM_BIT     = 2;
  localparam int MAX_CODEWORD_LENGTH = 16;

  localparam logic [1:0] CB_UNARY = 2'd0;
  localparam logic [1:0] CB_FIXED = 2'd1;
  localparam logic [1:0] CB_EXPG  = 2'd2;
  localparam logic [1:0] CB_ESC   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_UNARY,
    S_FIXED,
    S_EG_PREFIX,
    S_EG_SUFFIX,
    S_ESC_BODY
  } state_t;

endpackage

// File: rtl/multichannel_decoder_codebook_sel_table.sv
// Per-channel codebook select register file.
// Synchronous write, combinational read.
module codebook_sel_table #(
  parameter int N  = 16,
  parameter int IW = 4,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic [SW-1:0] wr_sel,
  input  logic [IW-1:0] rd_idx,
  output logic [SW-1:0] rd_sel
);

  logic [SW-1:0] tbl [N];

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < N; i++) tbl[i] <= '0;
    end else if (we) begin
      tbl[wr_idx] <= wr_sel;
    end
  end

  assign rd_sel = tbl[rd_idx];

endmodule

// File: rtl/multichannel_decoder.sv
// Serial prefix-codeword decoder: walks channels round-robin and
// emits one rate symbol per channel using its codebook select.
module multichannel_decoder #(
  parameter int CH_NUM          = multichannel_decoder_pkg::CH_NUM,
  parameter int CH_BIT          = multichannel_decoder_pkg::CH_BIT,
  parameter int SPIKE_RATE_BIT  = multichannel_decoder_pkg::SPIKE_RATE_BIT,
  parameter int ENCODER_NUM_BIT = multichannel_decoder_pkg::ENCODER_NUM_BIT
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       frame_start,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  input  logic                       cfg_we,
  input  logic [CH_BIT-1:0]          cfg_ch,
  input  logic [ENCODER_NUM_BIT-1:0] cfg_sel,
  output logic                       sym_valid,
  output logic [CH_BIT-1:0]          sym_ch,
  output logic [SPIKE_RATE_BIT-1:0]  sym_value,
  output logic                       sym_err,
  output logic                       frame_done,
  output logic                       busy
);

  import multichannel_decoder_pkg::*;

  localparam int SRB = SPIKE_RATE_BIT;
  localparam int ZW  = $clog2(SRB + 2);
  localparam int BW  = $clog2(SRB + 1);
  localparam logic [SRB-1:0]    RMAX = '1;
  localparam logic [CH_BIT-1:0] LAST = CH_BIT'(CH_NUM - 1);

  state_t                     state, st_n, st_e;
  logic [CH_BIT-1:0]          ch, ch_n, ch_e;
  logic [SRB-1:0]             cnt, cnt_n;
  logic [ZW-1:0]              zeros, zr_n;
  logic [SRB:0]               acc, acc_n, shifted, eg_v;
  logic [BW-1:0]              bcnt, bc_n;
  logic [ENCODER_NUM_BIT-1:0] sel;
  logic                       emit, err;
  logic [SRB-1:0]             val;

  codebook_sel_table #(
    .N  (CH_NUM),
    .IW (CH_BIT),
    .SW (ENCODER_NUM_BIT)
  ) u_tbl (
    .clk    (clk),
    .RST    (RST),
    .we     (cfg_we),
    .wr_idx (cfg_ch),
    .wr_sel (cfg_sel),
    .rd_idx (ch_e),
    .rd_sel (sel)
  );

  // frame_start overrides any partial codeword; a bit in the same
  // cycle is channel 0's first bit.
  assign st_e    = frame_start ? S_FIRST : state;
  assign ch_e    = frame_start ? '0 : ch;
  assign busy    = (state != S_IDLE);
  assign shifted = {acc[SRB-1:0], bit_in};
  assign eg_v    = shifted - (SRB+1)'(1);

  always_comb begin
    st_n  = st_e;
    ch_n  = ch_e;
    cnt_n = cnt;
    zr_n  = zeros;
    acc_n = acc;
    bc_n  = bcnt;
    emit  = 1'b0;
    err   = 1'b0;
    val   = '0;
    if (bit_valid) begin
      unique case (st_e)
        S_FIRST: begin
          case (sel)
            CB_UNARY: begin
              if (bit_in) begin
                cnt_n = SRB'(1);
                if (RMAX == SRB'(1)) begin
                  emit = 1'b1;
                  val  = RMAX;
                end else begin
                  st_n = S_UNARY;
                end
              end else begin
                emit = 1'b1;
              end
            end
            CB_FIXED: begin
              acc_n = (SRB+1)'(bit_in);
              bc_n  = BW'(1);
              if (BW'(1) == BW'(SRB)) begin
                emit = 1'b1;
                val  = SRB'(bit_in);
              end else begin
                st_n = S_FIXED;
              end
            end
            CB_EXPG: begin
              if (bit_in) begin
                emit = 1'b1;
              end else begin
                zr_n = ZW'(1);
                st_n = S_EG_PREFIX;
              end
            end
            default: begin
              if (bit_in) begin
                acc_n = '0;
                bc_n  = '0;
                st_n  = S_ESC_BODY;
              end else begin
                emit = 1'b1;
              end
            end
          endcase
        end
        S_UNARY: begin
          if (!bit_in) begin
            emit = 1'b1;
            val  = cnt;
          end else begin
            cnt_n = cnt + SRB'(1);
            if (cnt_n == RMAX) begin
              emit = 1'b1;
              val  = RMAX;
            end
          end
        end
        S_FIXED, S_ESC_BODY: begin
          acc_n = shifted;
          bc_n  = bcnt + BW'(1);
          if (bc_n == BW'(SRB)) begin
            emit = 1'b1;
            val  = shifted[SRB-1:0];
          end
        end
        S_EG_PREFIX: begin
          if (!bit_in) begin
            zr_n = zeros + ZW'(1);
            if (zr_n > ZW'(SRB)) begin
              emit = 1'b1;
              err  = 1'b1;
            end
          end else begin
            acc_n = (SRB+1)'(1);
            st_n  = S_EG_SUFFIX;
          end
        end
        S_EG_SUFFIX: begin
          acc_n = shifted;
          zr_n  = zeros - ZW'(1);
          if (zr_n == '0) begin
            emit = 1'b1;
            if (eg_v > {1'b0, RMAX}) err = 1'b1;
            else val = eg_v[SRB-1:0];
          end
        end
        default: ;
      endcase
    end
    if (emit) begin
      cnt_n = '0;
      zr_n  = '0;
      acc_n = '0;
      bc_n  = '0;
      if (ch_e == LAST) begin
        st_n = S_IDLE;
        ch_n = '0;
      end else begin
        st_n = S_FIRST;
        ch_n = ch_e + CH_BIT'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      ch         <= '0;
      cnt        <= '0;
      zeros      <= '0;
      acc        <= '0;
      bcnt       <= '0;
      sym_valid  <= 1'b0;
      sym_ch     <= '0;
      sym_value  <= '0;
      sym_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= st_n;
      ch         <= ch_n;
      cnt        <= cnt_n;
      zeros      <= zr_n;
      acc        <= acc_n;
      bcnt       <= bc_n;
      sym_valid  <= emit;
      sym_err    <= emit & err;
      frame_done <= emit && (ch_e == LAST);
      if (emit) begin
        sym_ch    <= ch_e;
        sym_value <= err ? RMAX : val;
      end
    end
  end

endmodule
